// File: rtl/execute_stage.sv
// execute_stage - EX stage of the 5-stage pipeline.
//
// Selects forwarded operands, runs the ALU, resolves branches and jumps,
// computes the branch target and registers results/control into the EX/MEM
// pipeline register that feeds the memory stage.
//
// Optional feature macro: EXECUTE_MULDIV_EN
//   Defined   : MulE starts a 32-step shift-add multiplier (low WIDTH bits of
//               SrcA*SrcB). StallE freezes F/D/E for 33 cycles per multiply.
//   Undefined : MulE is ignored, StallE is constant 0, no multiplier logic.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   RD1E, RD2E, ImmExtE   operands and sign-extended immediate from ID/EX
//   PCE, PCPlus4E         PC and PC+4 of the instruction in E
//   RdE, *E controls      decoded control for the instruction in E
//   ForwardAE/BE          00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = RDxE
//   ResultW               writeback result (forwarding source)
//   *M outputs            EX/MEM pipeline register
//   PCSrcE, PCTargetE     combinational fetch redirect and target
//   StallE                combinational freeze request for F/D/E
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ImmExtE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             JumpE,
  input  logic             BranchE,
  input  logic             ALUSrcE,
  input  logic             MulE,
  input  logic [1:0]       ResultSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic [4:0]       RdM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             StallE
);

  logic [WIDTH-1:0] src_a_s, src_b_s, write_data_s, alu_result_s, ex_result_s;
  logic             zero_s, pc_src_s, stall_s;

  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [4:0]       rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic [1:0]       result_src_q, result_src_d;

  // Forwarding muxes; code 11 falls back to the register-file operand.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a_s = ResultW;
      2'b10:   src_a_s = alu_result_q;
      default: src_a_s = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data_s = ResultW;
      2'b10:   write_data_s = alu_result_q;
      default: write_data_s = RD2E;
    endcase
    src_b_s = ALUSrcE ? ImmExtE : write_data_s;
  end

  // ALU; add/sub wrap, slt is signed, shifts use the low five bits of SrcB.
  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result_s = src_a_s + src_b_s;
      3'b001:  alu_result_s = src_a_s - src_b_s;
      3'b010:  alu_result_s = src_a_s & src_b_s;
      3'b011:  alu_result_s = src_a_s | src_b_s;
      3'b100:  alu_result_s = src_a_s ^ src_b_s;
      3'b101:  alu_result_s = {{(WIDTH-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
      3'b110:  alu_result_s = src_a_s << src_b_s[4:0];
      3'b111:  alu_result_s = src_a_s >> src_b_s[4:0];
      default: alu_result_s = {WIDTH{1'b0}};
    endcase
  end

  assign zero_s    = (alu_result_s == {WIDTH{1'b0}});
  assign PCTargetE = PCE + ImmExtE;

`ifdef EXECUTE_MULDIV_EN
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       count_q, count_d;

  // Multiplier next-state: operands are latched on entry so forwarding
  // changes while BUSY cannot disturb the product.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    stall_s  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        stall_s = MulE;
        if (MulE) begin
          mcand_d  = src_a_s;
          mplier_d = src_b_s;
          acc_d    = {WIDTH{1'b0}};
          count_d  = 5'd0;
          state_d  = MUL_BUSY;
        end else begin
          state_d  = MUL_IDLE;
        end
      end
      MUL_BUSY: begin
        stall_s = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = MUL_DONE;
        end else begin
          state_d = MUL_BUSY;
        end
      end
      MUL_DONE: begin
        stall_s = 1'b0;
        state_d = MUL_IDLE;
      end
      default: begin
        stall_s = 1'b0;
        state_d = MUL_IDLE;
      end
    endcase
  end

  // Multiplier state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  // A multiply never redirects fetch.
  assign ex_result_s = (state_q == MUL_DONE) ? acc_q : alu_result_s;
  assign pc_src_s    = ~MulE & (JumpE | (BranchE & zero_s));
`else
  // MulE has no function in this build; masking it keeps StallE constant 0.
  assign stall_s     = MulE & 1'b0;
  assign ex_result_s = alu_result_s;
  assign pc_src_s    = JumpE | (BranchE & zero_s);
`endif

  assign PCSrcE = pc_src_s;
  assign StallE = stall_s;

  // EX/MEM next value: a bubble while stalled, otherwise the E-stage results.
  always_comb begin
    if (stall_s) begin
      alu_result_d = {WIDTH{1'b0}};
      write_data_d = {WIDTH{1'b0}};
      pc_plus4_d   = {WIDTH{1'b0}};
      rd_d         = 5'd0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
    end else begin
      alu_result_d = ex_result_s;
      write_data_d = write_data_s;
      pc_plus4_d   = PCPlus4E;
      rd_d         = RdE;
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q <= {WIDTH{1'b0}};
      write_data_q <= {WIDTH{1'b0}};
      pc_plus4_q   <= {WIDTH{1'b0}};
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RdM        = rd_q;
  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_execute_stage;

  logic        clk, rst;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, MulE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM, PCSrcE, StallE;
  logic [1:0]  ResultSrcM;

  int n_pass  = 0;
  int n_total = 0;

  // Model's view of the EX/MEM register.
  logic [31:0] m_alu, m_wd, m_pc4;
  logic [4:0]  m_rd;
  logic        m_rw, m_mw;
  logic [1:0]  m_rs;

  execute_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .MulE(MulE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallE(StallE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [104:0] m_bundle();
    return {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
  endfunction

  function automatic logic [104:0] exp_bundle();
    return {m_alu, m_wd, m_pc4, m_rd, m_rw, m_mw, m_rs};
  endfunction

  // Reference ALU: shifts expressed as multiply/divide by a power of two.
  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] pow2;
    pow2 = 32'd1 << b[4:0];
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd6:    return a * pow2;
      default: return a / pow2;
    endcase
  endfunction

  function automatic logic [31:0] model_fwd(input logic [1:0] code, input logic [31:0] rd);
    if (code == 2'b01) return ResultW;
    if (code == 2'b10) return m_alu;
    return rd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RD1E = 32'd0; RD2E = 32'd0; ImmExtE = 32'd0; PCE = 32'd0; PCPlus4E = 32'd0;
    ResultW = 32'd0; RdE = 5'd0; RegWriteE = 1'b0; MemWriteE = 1'b0; JumpE = 1'b0;
    BranchE = 1'b0; ALUSrcE = 1'b0; MulE = 1'b0; ResultSrcE = 2'b00;
    ALUControlE = 3'd0; ForwardAE = 2'b00; ForwardBE = 2'b00;
  endtask

  // Advance the model by one non-stalled E->M transfer of the current inputs.
  task automatic model_load();
    logic [31:0] a, wd, b;
    a  = model_fwd(ForwardAE, RD1E);
    wd = model_fwd(ForwardBE, RD2E);
    b  = ALUSrcE ? ImmExtE : wd;
    m_alu = model_alu(ALUControlE, a, b);
    m_wd  = wd; m_pc4 = PCPlus4E; m_rd = RdE;
    m_rw  = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
  endtask

  task automatic model_zero();
    m_alu = 32'd0; m_wd = 32'd0; m_pc4 = 32'd0; m_rd = 5'd0;
    m_rw = 1'b0; m_mw = 1'b0; m_rs = 2'b00;
  endtask

  task automatic test_reset();
    n_total++;
    if (m_bundle() !== 105'd0) $display("FAIL reset_state: got %h expected 0", m_bundle());
    else n_pass++;
    n_total++;
    if (StallE !== 1'b0) $display("FAIL reset_stall: got %b expected 0", StallE);
    else n_pass++;
  endtask

  task automatic test_alu_forward();
    clear_inputs();
    RD1E = 32'd5; ResultW = 32'd7; ForwardAE = 2'b01; ImmExtE = 32'd3; ALUSrcE = 1'b1;
    ALUControlE = 3'b000; RegWriteE = 1'b1; RdE = 5'd9; PCPlus4E = 32'h44;
    tick(); model_load();
    n_total++;
    if (ALUResultM !== 32'd10) $display("FAIL fwd_w_add: got %h expected 0000000a", ALUResultM);
    else n_pass++;
    n_total++;
    if (m_bundle() !== exp_bundle()) $display("FAIL fwd_w_bundle: got %h expected %h", m_bundle(), exp_bundle());
    else n_pass++;
    RD1E = 32'hFFFF_FFFF; ForwardAE = 2'b00; ALUControlE = 3'b101;
    tick(); model_load();
    n_total++;
    if (ALUResultM !== 32'd1) $display("FAIL slt_neg: got %h expected 00000001", ALUResultM);
    else n_pass++;
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchE = 1'b1; ALUControlE = 3'b001; RD1E = 32'h40; RD2E = 32'h40;
    PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    n_total++;
    if ({PCSrcE, PCTargetE} !== {1'b1, 32'h120})
      $display("FAIL branch_taken: got %b/%h expected 1/00000120", PCSrcE, PCTargetE);
    else n_pass++;
    RD2E = 32'h41;
    #1;
    n_total++;
    if (PCSrcE !== 1'b0) $display("FAIL branch_not_taken: got %b expected 0", PCSrcE);
    else n_pass++;
    BranchE = 1'b0; JumpE = 1'b1;
    #1;
    n_total++;
    if (PCSrcE !== 1'b1) $display("FAIL jump: got %b expected 1", PCSrcE);
    else n_pass++;
    tick(); model_load();
  endtask

  task automatic test_forward_m();
    clear_inputs();
    RD1E = 32'd8; RD2E = 32'd8; RegWriteE = 1'b1; RdE = 5'd3;
    tick(); model_load();
    n_total++;
    if (ALUResultM !== 32'h10) $display("FAIL fwd_m_setup: got %h expected 00000010", ALUResultM);
    else n_pass++;
    RD1E = 32'd1; RD2E = 32'hDEAD; ForwardBE = 2'b10; MemWriteE = 1'b1; RegWriteE = 1'b0;
    tick(); model_load();
    n_total++;
    if (WriteDataM !== 32'h10) $display("FAIL fwd_m_wdata: got %h expected 00000010", WriteDataM);
    else n_pass++;
    RD2E = 32'h55; ForwardBE = 2'b11; ForwardAE = 2'b11; ResultW = 32'h77;
    tick(); model_load();
    n_total++;
    if ({WriteDataM, ALUResultM} !== {32'h55, 32'h56})
      $display("FAIL fwd_code11: got %h/%h expected 00000055/00000056", WriteDataM, ALUResultM);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, b, wd, res;
    logic        exp_pcsrc;
    for (int i = 0; i < 60; i++) begin
      RD1E = $urandom; RD2E = $urandom; ImmExtE = $urandom; PCE = $urandom;
      PCPlus4E = $urandom; ResultW = $urandom; RdE = 5'($urandom_range(0, 31));
      RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
      JumpE = ($urandom_range(0, 5) == 0); BranchE = 1'($urandom_range(0, 1));
      ALUSrcE = 1'($urandom_range(0, 1)); MulE = 1'b0;
      ResultSrcE = 2'($urandom_range(0, 3)); ALUControlE = 3'($urandom_range(0, 7));
      ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        // Make an equal compare likely so taken branches are exercised.
        ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0; ALUControlE = 3'b001;
        RD2E = RD1E;
      end
      a   = model_fwd(ForwardAE, RD1E);
      wd  = model_fwd(ForwardBE, RD2E);
      b   = ALUSrcE ? ImmExtE : wd;
      res = model_alu(ALUControlE, a, b);
      exp_pcsrc = JumpE | (BranchE & (res == 32'd0));
      #1;
      n_total++;
      if ({PCSrcE, PCTargetE, StallE} !== {exp_pcsrc, PCE + ImmExtE, 1'b0})
        $display("FAIL rand_comb[%0d]: got %b/%h/%b expected %b/%h/0", i, PCSrcE, PCTargetE,
                 StallE, exp_pcsrc, PCE + ImmExtE);
      else n_pass++;
      tick(); model_load();
      n_total++;
      if (m_bundle() !== exp_bundle())
        $display("FAIL rand_m[%0d] op=%0d: got %h expected %h", i, ALUControlE, m_bundle(), exp_bundle());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    RD1E = 32'h1234; RegWriteE = 1'b1; RdE = 5'd7; PCPlus4E = 32'h88; ResultSrcE = 2'b01;
    tick(); model_load();
    n_total++;
    if (m_bundle() !== exp_bundle()) $display("FAIL pre_reset: got %h expected %h", m_bundle(), exp_bundle());
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    model_zero();
    n_total++;
    if (m_bundle() !== 105'd0) $display("FAIL async_reset: got %h expected 0", m_bundle());
    else n_pass++;
    #2 rst = 1'b0;
  endtask

`ifdef EXECUTE_MULDIV_EN
  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input string name);
    int stalls;
    clear_inputs();
    @(posedge clk); #1;
    MulE = 1'b1; RD1E = a; RD2E = b; RegWriteE = 1'b1; RdE = 5'd12;
    PCPlus4E = 32'h204; JumpE = 1'b1; ResultSrcE = 2'b00;
    stalls = 0;
    #1;
    while (StallE === 1'b1 && stalls < 100) begin
      n_total++;
      if (PCSrcE !== 1'b0) $display("FAIL %s_pcsrc: got %b expected 0", name, PCSrcE);
      else n_pass++;
      stalls++;
      tick();
      n_total++;
      if (m_bundle() !== 105'd0) $display("FAIL %s_bubble[%0d]: got %h expected 0", name, stalls, m_bundle());
      else n_pass++;
      if (stalls > 1) begin
        ForwardAE = 2'b01; ResultW = $urandom;
      end
      #1;
    end
    n_total++;
    if (stalls !== 33) $display("FAIL %s_stall_len: got %0d expected 33", name, stalls);
    else n_pass++;
    tick();
    m_alu = a * b; m_wd = b; m_pc4 = 32'h204; m_rd = 5'd12;
    m_rw = 1'b1; m_mw = 1'b0; m_rs = 2'b00;
    n_total++;
    if (m_bundle() !== exp_bundle()) $display("FAIL %s_result: got %h expected %h", name, m_bundle(), exp_bundle());
    else n_pass++;
    clear_inputs();
    #1;
    n_total++;
    if (StallE !== 1'b0) $display("FAIL %s_idle: got %b expected 0", name, StallE);
    else n_pass++;
  endtask

  task automatic test_mul_reset();
    clear_inputs();
    @(posedge clk); #1;
    MulE = 1'b1; RD1E = 32'd1234; RD2E = 32'd99;
    for (int i = 0; i < 11; i++) tick();
    #2 rst = 1'b1; MulE = 1'b0;
    #1;
    model_zero();
    n_total++;
    if ({StallE, m_bundle()} !== 106'd0) $display("FAIL mul_reset: got %b/%h expected 0/0", StallE, m_bundle());
    else n_pass++;
    #2 rst = 1'b0;
    test_mul(32'd6, 32'd7, "mul_after_reset");
  endtask
`endif

  initial begin
    clear_inputs();
    model_zero();
    rst = 1'b1;
    #1;
    test_reset();
    #11 rst = 1'b0;
    test_alu_forward();
    test_branch();
    test_forward_m();
    test_random();
    test_reset_mid();
`ifdef EXECUTE_MULDIV_EN
    test_mul(32'hFFFF_FFFF, 32'd3, "mul_neg");
    test_mul_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
